// File: rtl/sh7034_itu_intc_pkg.sv
// Shared types and constants for the SH7034 ITU interrupt arbiter.
package sh7034_itu_intc_pkg;

    typedef logic [15:0] IPR_t;

    // IPRC only implements its low byte (channels 0 and 1).
    localparam IPR_t IPRC_INIT  = 16'h0000;
    localparam IPR_t IPRC_WMASK = 16'h00FF;
    localparam IPR_t IPRC_RMASK = 16'h00FF;

    // IPRD implements [15:4] (channels 2..4); [3:0] is unused here.
    localparam IPR_t IPRD_INIT  = 16'h0000;
    localparam IPR_t IPRD_WMASK = 16'hFFF0;
    localparam IPR_t IPRD_RMASK = 16'hFFF0;

    // Longword holding IPRC (bits 31:16) and IPRD (bits 15:0).
    localparam logic [27:0] IPR_ADDR = 28'h5FFFF88;

    // ITU vector layout: channel n, source s -> base + 4*n + s.
    localparam int ITU_VEC_BASE = 80;
    localparam int ITU_CHANNELS = 5;
    localparam int ITU_SOURCES  = 3;
    localparam int ITU_LINES    = ITU_CHANNELS * ITU_SOURCES;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PEND,
        ST_HOLD,
        ST_GAP
    } INTC_STATE_t;

    // Line index is 3*ch + src; vector offset is 4*ch + src = idx + ch.
    function automatic logic [7:0] itu_vec_ofs(input logic [3:0] idx);
        return 8'(idx) + 8'(idx / 4'd3);
    endfunction

endpackage

// File: rtl/sh7034_irq_prio_enc.sv
// Priority encoder over the 15 ITU lines: highest level wins, ties go to
// the lowest line index (lower channel first, then IMIA > IMIB > OVI).
module sh7034_irq_prio_enc
    import sh7034_itu_intc_pkg::*;
(
    input  logic [ITU_LINES-1:0][3:0] lvl,
    input  logic [ITU_LINES-1:0]      line,
    output logic [3:0]                win_lvl,
    output logic [3:0]                win_idx,
    output logic                      win_valid
);

    // Scan upward with strict compare so an equal level never displaces an earlier line.
    always_comb begin
        win_lvl   = '0;
        win_idx   = '0;
        win_valid = 1'b0;
        for (int i = 0; i < ITU_LINES; i++) begin
            if (line[i] && (lvl[i] > win_lvl)) begin
                win_lvl   = lvl[i];
                win_idx   = 4'(i);
                win_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sh7034_itu_intc.sv
// SH7034 ITU interrupt controller slice: IPRC/IPRD registers, IBUS access,
// arbitration of the 15 ITU requests and the CPU acknowledge handshake.
module sh7034_itu_intc
    import sh7034_itu_intc_pkg::*;
#(
    parameter int VEC_BASE = ITU_VEC_BASE
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        CE_R,
    input  logic        CE_F,
    input  logic [4:0]  IMIA_IRQ,
    input  logic [4:0]  IMIB_IRQ,
    input  logic [4:0]  OVI_IRQ,
    input  logic [27:0] IBUS_A,
    input  logic [31:0] IBUS_DI,
    output logic [31:0] IBUS_DO,
    input  logic [3:0]  IBUS_BA,
    input  logic        IBUS_WE,
    input  logic        IBUS_REQ,
    output logic        IBUS_BUSY,
    output logic        IBUS_ACT,
    input  logic [3:0]  INT_MASK,
    output logic        INT_REQ,
    output logic [3:0]  INT_LVL,
    output logic [7:0]  INT_VEC,
    input  logic        INT_ACK,
    output logic        INT_ACKD
);

    IPR_t        iprc;
    IPR_t        iprd;
    INTC_STATE_t state;

    logic [ITU_CHANNELS-1:0][3:0] ch_lvl;
    logic [ITU_LINES-1:0][3:0]    line_lvl;
    logic [ITU_LINES-1:0]         line_act;
    logic [3:0]                   win_lvl;
    logic [3:0]                   win_idx;
    logic                         win_valid;
    logic [7:0]                   win_vec;
    logic                         req_valid;
    logic [31:0]                  wr_be;
    IPR_t                         iprc_be;
    IPR_t                         iprd_be;
    logic                         wr_en;

    assign IBUS_BUSY = 1'b0;
    assign IBUS_ACT  = (IBUS_A == IPR_ADDR);
    assign wr_en     = IBUS_ACT & IBUS_WE & IBUS_REQ;

    assign wr_be   = {{8{IBUS_BA[3]}}, {8{IBUS_BA[2]}}, {8{IBUS_BA[1]}}, {8{IBUS_BA[0]}}};
    assign iprc_be = wr_be[31:16] & IPRC_WMASK;
    assign iprd_be = wr_be[15:0]  & IPRD_WMASK;

    // Element n is the priority field of ITU channel n.
    assign ch_lvl = {iprd[7:4], iprd[11:8], iprd[15:12], iprc[3:0], iprc[7:4]};

    // Spread channel levels and request lines into the 3*ch + src line order.
    always_comb begin
        line_lvl = '0;
        line_act = '0;
        for (int n = 0; n < ITU_CHANNELS; n++) begin
            line_lvl[3*n+0] = ch_lvl[n];
            line_lvl[3*n+1] = ch_lvl[n];
            line_lvl[3*n+2] = ch_lvl[n];
            line_act[3*n+0] = IMIA_IRQ[n];
            line_act[3*n+1] = IMIB_IRQ[n];
            line_act[3*n+2] = OVI_IRQ[n];
        end
    end

    sh7034_irq_prio_enc u_enc (
        .lvl       (line_lvl),
        .line      (line_act),
        .win_lvl   (win_lvl),
        .win_idx   (win_idx),
        .win_valid (win_valid)
    );

    assign win_vec   = win_valid ? (8'(VEC_BASE) + itu_vec_ofs(win_idx)) : 8'h00;
    assign req_valid = win_valid && (win_lvl > INT_MASK);

    // Priority registers: byte-enabled writes on the rising phase.
    always_ff @(posedge CLK) begin
        if (RST) begin
            iprc <= IPRC_INIT;
            iprd <= IPRD_INIT;
        end else if (CE_R && wr_en) begin
            iprc <= (iprc & ~iprc_be) | (IBUS_DI[31:16] & iprc_be);
            iprd <= (iprd & ~iprd_be) | (IBUS_DI[15:0]  & iprd_be);
        end
    end

    // Read data captured on the falling phase; zero whenever not selected for a read.
    always_ff @(posedge CLK) begin
        if (RST) begin
            IBUS_DO <= '0;
        end else if (CE_F) begin
            if (IBUS_ACT && IBUS_REQ && !IBUS_WE) begin
                IBUS_DO <= {iprc & IPRC_RMASK, iprd & IPRD_RMASK};
            end else begin
                IBUS_DO <= '0;
            end
        end
    end

    // Request/acknowledge handshake with registered CPU-facing outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= ST_IDLE;
            INT_REQ  <= 1'b0;
            INT_LVL  <= '0;
            INT_VEC  <= '0;
            INT_ACKD <= 1'b0;
        end else if (CE_R) begin
            INT_ACKD <= 1'b0;
            case (state)
                ST_IDLE: begin
                    INT_LVL <= win_lvl;
                    INT_VEC <= win_vec;
                    INT_REQ <= req_valid;
                    if (req_valid) begin
                        state <= ST_PEND;
                    end
                end
                ST_PEND: begin
                    // Acknowledge takes precedence over a request that drops in the same cycle.
                    if (INT_ACK) begin
                        INT_ACKD <= 1'b1;
                        INT_REQ  <= 1'b0;
                        state    <= ST_HOLD;
                    end else if (!req_valid) begin
                        INT_REQ <= 1'b0;
                        state   <= ST_IDLE;
                    end else if (win_lvl > INT_LVL) begin
                        INT_LVL <= win_lvl;
                        INT_VEC <= win_vec;
                    end
                end
                ST_HOLD: begin
                    if (!INT_ACK) begin
                        state <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    // One quiet cycle lets the CPU mask and ISR flag clear settle.
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
